// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// State enum, default widths, port indices, counter-width helper.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 64;
  localparam int DATA_W_DEF = 64;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_e;

  // Bits needed to hold 0..max, never less than one.
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Bus bundle between the fetch/data requesters, arbiter and memory.
// slave: arbiter side; master: requesters plus memory model.
interface mem_arb_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req,
    input  if_addr,
    output if_rdata,
    output if_ready,
    input  dm_req,
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    output dm_rdata,
    output dm_ready,
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    output stall_if,
    output stall_mem
  );

  modport master (
    output if_req,
    output if_addr,
    input  if_rdata,
    input  if_ready,
    output dm_req,
    output dm_we,
    output dm_addr,
    output dm_wdata,
    input  dm_rdata,
    input  dm_ready,
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    input  stall_if,
    input  stall_mem
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection with fetch anti-starvation counter update.
// In: if_req_i, dm_req_i, starve_i. Out: grant_o, port_o, starve_o.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int SW         = cnt_w(STARVE_MAX)
) (
  input  logic          if_req_i,
  input  logic          dm_req_i,
  input  logic [SW-1:0] starve_i,
  output logic          grant_o,
  output logic          port_o,
  output logic [SW-1:0] starve_o
);

  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic starved;
  logic dm_win;
  logic if_win;

  always_comb begin
    starved  = (starve_i == SMAX);
    dm_win   = dm_req_i & ~(if_req_i & starved);
    if_win   = if_req_i & ~dm_win;
    grant_o  = if_req_i | dm_req_i;
    port_o   = PORT_IF;
    starve_o = starve_i;
    unique case (1'b1)
      dm_win: begin
        port_o = PORT_DM;
        // only count data wins that actually made fetch wait
        if (if_req_i && !starved)
          starve_o = starve_i + 1'b1;
      end
      if_win: begin
        starve_o = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) single-memory arbiter, IDLE/ISSUE/WAIT/DONE.
// Ports: clk, rst (async high), bus (mem_arb_if.slave).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LAT        = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic     clk,
  input  logic     rst,
  mem_arb_if.slave bus
);

  localparam int SW = cnt_w(STARVE_MAX);
  localparam int WW = cnt_w(LAT);
  localparam logic [WW-1:0] WLAST = WW'(LAT - 1);

  arb_state_e state_q;

  logic              port_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              mem_en_q;
  logic              if_ready_q;
  logic              dm_ready_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic [SW-1:0]     starve_q;
  logic [SW-1:0]     starve_d;
  logic [WW-1:0]     wait_q;

  logic              pick_grant;
  logic              pick_port;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .SW         (SW)
  ) u_pick (
    .if_req_i (bus.if_req),
    .dm_req_i (bus.dm_req),
    .starve_i (starve_q),
    .grant_o  (pick_grant),
    .port_o   (pick_port),
    .starve_o (starve_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      port_q     <= PORT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_en_q   <= 1'b0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      starve_q   <= '0;
      wait_q     <= '0;
    end else begin
      mem_en_q   <= 1'b0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_grant) begin
            port_q   <= pick_port;
            starve_q <= starve_d;
            if (pick_port == PORT_DM) begin
              we_q    <= bus.dm_we;
              addr_q  <= bus.dm_addr;
              wdata_q <= bus.dm_wdata;
            end else begin
              we_q    <= 1'b0;
              addr_q  <= bus.if_addr;
              wdata_q <= '0;
            end
            mem_en_q <= 1'b1;
            state_q  <= ISSUE;
          end
        end
        ISSUE: begin
          wait_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (wait_q == WLAST) begin
            // memory data is valid on this edge only
            if (!we_q) begin
              if (port_q == PORT_DM)
                dm_rdata_q <= bus.mem_rdata;
              else
                if_rdata_q <= bus.mem_rdata;
            end
            if (port_q == PORT_DM)
              dm_ready_q <= 1'b1;
            else
              if_ready_q <= 1'b1;
            state_q <= DONE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        DONE: begin
          // no grant here: a held req waits for IDLE
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.stall_if  = bus.if_req & ~if_ready_q;
  assign bus.stall_mem = bus.dm_req & ~dm_ready_q;

  a_en_gap: assert property (
    @(posedge clk) disable iff (rst)
    mem_en_q |=> !mem_en_q
  );

  a_rdy_excl: assert property (
    @(posedge clk) disable iff (rst)
    !(if_ready_q && dm_ready_q)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: random requesters, memory slave,
// transaction-level reference model checked every cycle.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  mem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .LAT        (LAT),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  function automatic void check(string nm, logic [255:0] act,
                                logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // requester <-> scoreboard shared state
  txn_t q_if[$];
  txn_t q_dm[$];
  bit   pend[2];
  bit   granted[2];
  bit   done[2];

  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] slv_mem [logic [AW-1:0]];

  // reference model state
  int            free_at = 0;
  int            rdy_cyc = -1;
  int            starve_m = 0;
  logic          cur_port;
  logic          cur_we;
  logic [DW-1:0] cur_rd;
  logic [AW-1:0] e_addr;
  logic          e_we;
  logic [DW-1:0] e_wdata;
  logic [DW-1:0] e_if_rd;
  logic [DW-1:0] e_dm_rd;
  int            order[$];
  int            en_cyc = 0;
  int            if_rdy_at = 0;
  int            dm_rdy_at = 0;
  int            completions = 0;

  always @(negedge clk) begin : mon
    bit   g, win, r_if, r_dm;
    txn_t t;
    if (rst) begin
      check("rst_ctl", 256'({bus.mem_en, bus.mem_we,
            bus.if_ready, bus.dm_ready}), 256'(0));
      check("rst_mem", 256'({bus.mem_addr, bus.mem_wdata}),
            256'(0));
      check("rst_rd", 256'({bus.if_rdata, bus.dm_rdata}),
            256'(0));
      free_at  = cyc + 1;
      rdy_cyc  = -1;
      starve_m = 0;
      e_addr   = '0;
      e_we     = 1'b0;
      e_wdata  = '0;
      e_if_rd  = '0;
      e_dm_rd  = '0;
      q_if.delete();
      q_dm.delete();
      order.delete();
      granted[0] = 1'b0;
      granted[1] = 1'b0;
    end else begin
      g = (cyc >= free_at) && (bus.if_req || bus.dm_req);
      if (g) begin
        // data wins unless fetch has lost SMAX times in a row
        win = bus.dm_req && !(bus.if_req && starve_m == SMAX);
        if (win) begin
          if (bus.if_req && starve_m < SMAX) starve_m++;
          check("dm_txn_queued", 256'(q_dm.size() != 0), 256'(1));
          t = (q_dm.size() != 0) ? q_dm.pop_front()
                                 : '{'0, 1'b0, '0};
        end else begin
          starve_m = 0;
          check("if_txn_queued", 256'(q_if.size() != 0), 256'(1));
          t = (q_if.size() != 0) ? q_if.pop_front()
                                 : '{'0, 1'b0, '0};
        end
        cur_port = win;
        cur_we   = t.we;
        cur_rd   = ref_mem.exists(t.addr) ? ref_mem[t.addr] : '0;
        if (t.we) ref_mem[t.addr] = t.wdata;
        e_addr  = t.addr;
        e_we    = t.we;
        e_wdata = t.wdata;
        rdy_cyc = cyc + 1 + LAT;
        free_at = cyc + 3 + LAT;
        granted[win] = 1'b1;
      end
      r_if = (cyc == rdy_cyc) && !cur_port;
      r_dm = (cyc == rdy_cyc) && cur_port;
      if (r_if && !cur_we) e_if_rd = cur_rd;
      if (r_dm && !cur_we) e_dm_rd = cur_rd;
      check("mem_en", 256'(bus.mem_en), 256'(g));
      check("mem_attr",
            256'({bus.mem_we, bus.mem_addr, bus.mem_wdata}),
            256'({e_we, e_addr, e_wdata}));
      check("if_ready", 256'(bus.if_ready), 256'(r_if));
      check("dm_ready", 256'(bus.dm_ready), 256'(r_dm));
      check("if_rdata", 256'(bus.if_rdata), 256'(e_if_rd));
      check("dm_rdata", 256'(bus.dm_rdata), 256'(e_dm_rd));
      check("stall_if", 256'(bus.stall_if),
            256'(bus.if_req && !r_if));
      check("stall_mem", 256'(bus.stall_mem),
            256'(bus.dm_req && !r_dm));
      if (r_if) begin
        done[0] = 1'b1; granted[0] = 1'b0; completions++;
      end
      if (r_dm) begin
        done[1] = 1'b1; granted[1] = 1'b0; completions++;
      end
      if (bus.mem_en) en_cyc = cyc;
      if (bus.if_ready) begin
        order.push_back(0); if_rdy_at = cyc;
      end
      if (bus.dm_ready) begin
        order.push_back(1); dm_rdy_at = cyc;
      end
    end
  end

  // memory slave: data valid only on the LAT-th cycle after mem_en
  int            due = -1;
  logic [AW-1:0] sa;
  always @(negedge clk) begin : slave
    if (rst) begin
      due = -1;
    end else if (bus.mem_en) begin
      due = cyc + LAT;
      sa  = bus.mem_addr;
      if (bus.mem_we) slv_mem[bus.mem_addr] = bus.mem_wdata;
    end
    if (cyc == due)
      bus.mem_rdata = slv_mem.exists(sa) ? slv_mem[sa] : '0;
    else
      bus.mem_rdata = rand64();
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(int p, bit req, bit we,
                       logic [AW-1:0] a, logic [DW-1:0] d);
    if (p == 0) begin
      bus.if_req  = req;
      bus.if_addr = a;
    end else begin
      bus.dm_req   = req;
      bus.dm_we    = we;
      bus.dm_addr  = a;
      bus.dm_wdata = d;
    end
  endtask

  task automatic new_txn(int p, logic [AW-1:0] a, bit we,
                         logic [DW-1:0] d);
    txn_t t;
    pend[p]    = 1'b1;
    granted[p] = 1'b0;
    drive(p, 1'b1, we, a, d);
    t.addr  = a;
    t.we    = (p == 1) ? we : 1'b0;
    t.wdata = (p == 1) ? d : '0;
    if (p == 1) q_dm.push_back(t);
    else        q_if.push_back(t);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return 64'h100 + 64'(8 * $urandom_range(0, 7));
  endfunction

  task automatic port_tick(int p, int pct);
    if (done[p]) begin
      done[p] = 1'b0;
      pend[p] = 1'b0;
    end
    if (pend[p]) begin
      // after the grant, attributes and req may wander freely
      if (granted[p])
        drive(p, $urandom_range(0, 3) != 0, 1'($urandom),
              rand64(), rand64());
    end else if ($urandom_range(0, 99) < pct) begin
      new_txn(p, rand_addr(), 1'($urandom_range(0, 1)), rand64());
    end else begin
      drive(p, 1'b0, 1'($urandom), rand64(), rand64());
    end
  endtask

  task automatic run(int n, int pct0, int pct1);
    repeat (n) begin
      step();
      port_tick(0, pct0);
      port_tick(1, pct1);
    end
  endtask

  task automatic wait_port(int p, string nm);
    bit seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step();
      seen = done[p];
      port_tick(0, 0);
      port_tick(1, 0);
    end
    if (!seen) check({nm, "_timeout"}, 256'(0), 256'(1));
  endtask

  task automatic do_reset(int n);
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    pend[0] = 1'b0; pend[1] = 1'b0;
    done[0] = 1'b0; done[1] = 1'b0;
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  int exp_ord[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    bit seen;
    bus.mem_rdata = '0;
    ref_mem[64'h10] = 64'hAA;
    slv_mem[64'h10] = 64'hAA;
    do_reset(3);

    // fetch read of a preloaded word
    new_txn(0, 64'h10, 1'b0, '0);
    wait_port(0, "if_rd");
    check("if_lat", 256'(if_rdy_at - en_cyc), 256'(LAT + 1));
    check("if_rdata_aa", 256'(bus.if_rdata), 256'(64'hAA));

    // data write
    new_txn(1, 64'h40, 1'b1, 64'h55);
    wait_port(1, "dm_wr");
    check("dm_lat", 256'(dm_rdy_at - en_cyc), 256'(LAT + 1));
    check("dm_wr_rdata", 256'(bus.dm_rdata), 256'(0));

    // both held: fetch wins once every SMAX data grants
    do_reset(2);
    run(60, 100, 100);
    check("order_len", 256'(order.size() >= 10), 256'(1));
    for (int i = 0; i < 10 && i < order.size(); i++)
      check($sformatf("order_%0d", i), 256'(order[i]),
            256'(exp_ord[i]));

    // reset in the middle of WAIT abandons the transfer
    do_reset(2);
    new_txn(0, rand_addr(), 1'b0, '0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      step();
      seen = granted[0];
    end
    if (!seen) check("rst_grant_timeout", 256'(0), 256'(1));
    step();
    do_reset(3);
    run(4, 0, 0);
    new_txn(0, 64'h10, 1'b0, '0);
    wait_port(0, "post_rst");
    check("post_rst_lat", 256'(if_rdy_at - en_cyc), 256'(LAT + 1));

    // random traffic, light then heavy
    do_reset(2);
    run(3000, 30, 40);
    run(1000, 90, 90);
    run(20, 0, 0);
    check("completions", 256'(completions > 200), 256'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- LAT, 2, memory read latency in cycles (>=1).
- STARVE_MAX, 4, consecutive data-port wins allowed while fetch waits.

REQ-002 Ports (name, direction, width, meaning), one per line; clock and reset first:
- clk, in, 1, single clock, all logic rising-edge.
- rst, in, 1, asynchronous, active-high reset.
- if_req, in, 1, fetch-port request.
- if_addr, in, ADDR_W, fetch address.
- if_rdata, out, DATA_W, fetch read data.
- if_ready, out, 1, fetch completion pulse.
- dm_req, in, 1, data-port request.
- dm_we, in, 1, data-port write.
- dm_addr, in, ADDR_W, data-port address.
- dm_wdata, in, DATA_W, data-port write data.
- dm_rdata, out, DATA_W, data-port read data.
- dm_ready, out, 1, data-port completion pulse.
- mem_en, out, 1, memory access strobe.
- mem_we, out, 1, memory write.
- mem_addr, out, ADDR_W, memory address.
- mem_wdata, out, DATA_W, memory write data.
- mem_rdata, in, DATA_W, memory read data.
- stall_if, out, 1, hold fetch stage.
- stall_mem, out, 1, hold MEM stage.

REQ-003 One clock; reset is asynchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE.
REQ-005 IDLE: with any req sampled high, the block SHALL select a winner and latch its addr/we/wdata, then go to ISSUE; with no req, it SHALL stay in IDLE.
REQ-006 Fetch transactions SHALL latch mem_we=0.
REQ-007 Priority: data port SHALL win when both ports request, except when starve_cnt==STARVE_MAX; then fetch SHALL win.
REQ-008 starve_cnt SHALL increment, saturating at STARVE_MAX, on each data grant made while if_req is high, and SHALL clear on any fetch grant.
REQ-009 ISSUE: mem_en SHALL be 1 for exactly this one cycle, with mem_we/mem_addr/mem_wdata driven from the latched values; the FSM SHALL then go to WAIT.
REQ-010 mem_addr/mem_we/mem_wdata SHALL hold the latched values until the next grant.
REQ-011 WAIT SHALL last exactly LAT cycles, counted by a wait counter.
REQ-012 At the end of the last WAIT cycle, mem_rdata SHALL be captured into the winner's rdata register, for reads only; the other port's rdata and all write results SHALL stay unchanged.
REQ-013 DONE: the winner's ready SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-014 No grant SHALL be made in DONE, so a request still held in that cycle is not re-issued.
REQ-015 Latency: a req first sampled in IDLE at cycle t SHALL give mem_en at t+1 and ready at t+2+LAT (t+4 for LAT=2).
REQ-016 stall_if SHALL equal if_req & ~if_ready, and stall_mem SHALL equal dm_req & ~dm_ready, both combinational.
REQ-017 Requesters hold req and attributes until ready; a req dropped mid-transaction SHALL NOT abort it, and ready SHALL still pulse.
REQ-018 Attribute changes after the grant SHALL be ignored.
REQ-019 if_ready and dm_ready SHALL never be high in the same cycle.
REQ-020 mem_en SHALL never be high in two consecutive cycles.

Reset
REQ-021 rst SHALL force state IDLE and zero every output register, starve_cnt and the wait counter, asynchronously.
REQ-022 Reset asserted mid-transaction SHALL abandon it: no ready pulse and no further mem_en.
REQ-023 After rst deasserts, the first grant SHALL come no earlier than the first IDLE edge.

Structure
REQ-024 Package mem_arb_pkg SHALL hold the state enum, default ADDR_W/DATA_W, and port-index constants (PORT_IF=0, PORT_DM=1).
REQ-025 Winner selection and starve_cnt update SHALL be in sub-module mem_arb_pick; the FSM, latches and counters SHALL be in mem_arbiter.

Verification
REQ-026 Fetch read only, if_addr=0x10, mem_rdata=0xAA at mem_en+2 -> mem_en at t+1, if_ready at t+4, if_rdata=0xAA, stall_if high t..t+3.
REQ-027 Data write, dm_addr=0x40, dm_wdata=0x55 -> mem_we=1, mem_wdata=0x55, dm_ready at t+4, dm_rdata unchanged.
REQ-028 Both req held continuously -> grant order DM,DM,DM,DM,IF,DM,...; starve_cnt clears after the IF grant.
REQ-029 Requests held through DONE -> no mem_en in DONE; next mem_en follows the IDLE cycle; mem_en never high on consecutive cycles.
REQ-030 rst pulsed during WAIT -> all outputs 0, no ready; a fresh req afterwards completes normally at t+4.
